buffer_ctrl: RTL and testbench
==============================

Name: buffer_ctrl

Overview:
- Pointer and occupancy controller that sits directly upstream of the circular multi-word buffer and drives its write_addr, read_addr and write_en.
- Producer side: accepts WRITE_SIZE-word bursts through a valid/ready handshake.
- Consumer side: offers a READ_SIZE-word window through a valid/ready handshake; each consumer accept retires STRIDE words, giving a sliding window for the datapath.

Parameters:
- SIZE, 8, buffer depth in words; power of two, SIZE >= WRITE_SIZE and SIZE >= READ_SIZE.
- WRITE_SIZE, 2, words written per accepted write.
- READ_SIZE, 2, words visible per read window.
- STRIDE, 1, words retired per accepted read; 1 <= STRIDE <= READ_SIZE.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous clear of pointers and count.
- wr_valid  input  1  producer has a WRITE_SIZE-word burst on the buffer data inputs.
- wr_ready  output  1  at least WRITE_SIZE free words.
- rd_valid  output  1  at least READ_SIZE stored words.
- rd_ready  input  1  consumer takes the current window.
- write_en  output  1  to buffer.
- write_addr  output  $clog2(SIZE)  to buffer, base word index of the write.
- read_addr  output  $clog2(SIZE)  to buffer, base word index of the window.
- count  output  $clog2(SIZE+1)  stored word count.
- full  output  1  count == SIZE.
- empty  output  1  count == 0.

Behaviour:
- Reset, asynchronous on rst low, held while low:
  - wptr = 0, rptr = 0, count = 0.
  - Outputs: write_addr = 0, read_addr = 0, empty = 1, full = 0, rd_valid = 0, write_en = 0, wr_ready = 1.
  - Reset mid-burst discards all content; no partial state survives.
- Derived signals, all combinational from registered count:
  - free = SIZE - count.
  - wr_ready = (free >= WRITE_SIZE).
  - rd_valid = (count >= READ_SIZE).
  - full = (count == SIZE); empty = (count == 0).
- Handshake fires:
  - wfire = wr_valid & wr_ready.
  - rfire = rd_valid & rd_ready.
  - write_en = wfire, combinational. The buffer stores the burst on the same edge.
- Outputs write_addr = wptr and read_addr = rptr, both registered.
- Pointer update on a clock edge:
  - wfire: wptr <= (wptr + WRITE_SIZE) mod SIZE.
  - rfire: rptr <= (rptr + STRIDE) mod SIZE.
  - Pointer arithmetic is natural wrap in $clog2(SIZE) bits.
- Count update: count <= count + (wfire ? WRITE_SIZE : 0) - (rfire ? STRIDE : 0).
  - Evaluate at $clog2(SIZE+1)+1 bits; the result is never negative or above SIZE.
- Simultaneous write and read:
  - Both fire in the same cycle.
  - ready/valid are evaluated against the pre-edge count; there is no bypass.
  - A read never sees words written in the same cycle.
- Write-to-read latency is 1 cycle: data written at edge N is counted, and may raise rd_valid, after edge N.
- flush (synchronous, when rst is high) forces wptr = rptr = count = 0 at the edge.
  - flush overrides wfire/rfire in that cycle.
  - write_en is still asserted if wfire, but the data is discarded logically.
- Full: wr_ready = 0 and write_en = 0 regardless of wr_valid. Empty or count < READ_SIZE: rd_valid = 0.
- Any free count below WRITE_SIZE (including 0 < free < WRITE_SIZE) deasserts wr_ready; a partial burst is never accepted.
- wr_ready and rd_valid do not depend combinationally on wr_valid or rd_ready.

Test Plan (defaults SIZE=8, WRITE_SIZE=2, READ_SIZE=2, STRIDE=1):
- Reset: drive rst low mid-operation with count=5 -> immediately count=0, empty=1, rd_valid=0, wr_ready=1, write_addr=read_addr=0.
- Fill: 4 consecutive wfire with rd_ready=0 -> write_addr 0,2,4,6, count 2,4,6,8. After the 4th: full=1, wr_ready=0, write_en=0 with wr_valid=1; write_addr wraps to 0.
- Window: one write (count=2), then rd_ready=1 -> rd_valid=1, rfire; next cycle count=1, read_addr=1, rd_valid=0.
- Simultaneous: count=6 with wptr=6, rptr=0; assert wr_valid and rd_ready together -> next cycle count=7, write_addr=0, read_addr=1, wr_ready=0.
- Read wrap: rptr=7, count=3, rfire -> read_addr=0, count=2. Window words must come from indices 7 and 0 (checked via the buffer model).
- Flush: count=4, flush=1 with wr_valid=1 -> next cycle count=0, write_addr=read_addr=0, empty=1.

Source files
------------

// File: rtl/buffer_ctrl.sv
// Pointer and occupancy controller for a circular multi-word buffer.
// Producer bursts of WRITE_SIZE words; consumer window of READ_SIZE words.
module buffer_ctrl #(
    parameter int SIZE       = 8,
    parameter int WRITE_SIZE = 2,
    parameter int READ_SIZE  = 2,
    parameter int STRIDE     = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic                       write_en,
    output logic [$clog2(SIZE)-1:0]    write_addr,
    output logic [$clog2(SIZE)-1:0]    read_addr,
    output logic [$clog2(SIZE+1)-1:0]  count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(SIZE);
    localparam int CW = $clog2(SIZE + 1);

    localparam logic [CW:0]   SIZE_C = (CW+1)'(SIZE);
    localparam logic [CW:0]   WS_C   = (CW+1)'(WRITE_SIZE);
    localparam logic [CW:0]   RS_C   = (CW+1)'(READ_SIZE);
    localparam logic [CW:0]   ST_C   = (CW+1)'(STRIDE);
    localparam logic [AW-1:0] WINC   = AW'(WRITE_SIZE);
    localparam logic [AW-1:0] RINC   = AW'(STRIDE);

    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW:0]   cnt_ext;
    logic [CW:0]   free;
    logic          wfire, rfire;

    // Handshake status derives only from the registered count.
    always_comb begin
        free     = SIZE_C - {1'b0, count_q};
        wr_ready = (free >= WS_C);
        rd_valid = ({1'b0, count_q} >= RS_C);
        full     = ({1'b0, count_q} == SIZE_C);
        empty    = (count_q == '0);
        wfire    = wr_valid & wr_ready;
        rfire    = rd_valid & rd_ready;
        write_en = wfire;
    end

    always_comb begin
        cnt_ext = {1'b0, count_q};
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        if (wfire) begin
            cnt_ext = cnt_ext + WS_C;
            wptr_d  = wptr_q + WINC;
        end
        if (rfire) begin
            cnt_ext = cnt_ext - ST_C;
            rptr_d  = rptr_q + RINC;
        end
        count_d = cnt_ext[CW-1:0];
        // A flushed burst is still strobed into the buffer but never counted.
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    assign write_addr = wptr_q;
    assign read_addr  = rptr_q;
    assign count      = count_q;

endmodule

// File: tb/tb_buffer_ctrl.sv
// Directed bench for buffer_ctrl with a buffer model and a word scoreboard.
// Every cycle checks handshake/pointer outputs against a reference model.
module tb_buffer_ctrl;

    localparam int SIZE = 8;
    localparam int WS   = 2;
    localparam int RS   = 2;
    localparam int ST   = 1;

    logic       clk = 0;
    logic       rst = 0;
    logic       flush = 0;
    logic       wr_valid = 0;
    logic       rd_ready = 0;
    logic       wr_ready, rd_valid, write_en, full, empty;
    logic [2:0] write_addr, read_addr;
    logic [3:0] count;

    logic [7:0] mem [SIZE];
    logic [7:0] wdata0 = 0, wdata1 = 0;
    logic [7:0] next_word = 8'h10;
    logic [7:0] sb [$];

    int m_cnt = 0, m_wp = 0, m_rp = 0;
    int total = 0, bad = 0;

    buffer_ctrl #(.SIZE(SIZE), .WRITE_SIZE(WS), .READ_SIZE(RS), .STRIDE(ST)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_valid(rd_valid), .rd_ready(rd_ready),
        .write_en(write_en), .write_addr(write_addr),
        .read_addr(read_addr), .count(count),
        .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (write_en) begin
            mem[write_addr]                    <= wdata0;
            mem[3'(int'(write_addr) + 1)]      <= wdata1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_state();
        chk("count", 32'(count), 32'(m_cnt));
        chk("write_addr", 32'(write_addr), 32'(m_wp));
        chk("read_addr", 32'(read_addr), 32'(m_rp));
        chk("full", 32'(full), 32'(m_cnt == SIZE));
        chk("empty", 32'(empty), 32'(m_cnt == 0));
        chk("wr_ready", 32'(wr_ready), 32'((SIZE - m_cnt) >= WS));
        chk("rd_valid", 32'(rd_valid), 32'(m_cnt >= RS));
    endtask

    // One clock: drive, check pre-edge outputs, advance model after the edge.
    task automatic step(input logic wv, input logic rv, input logic fl);
        bit wf, rf;
        wr_valid = wv;
        rd_ready = rv;
        flush    = fl;
        wdata0   = next_word;
        wdata1   = next_word + 8'd1;
        #1;
        wf = wv && ((SIZE - m_cnt) >= WS);
        rf = rv && (m_cnt >= RS);
        chk_state();
        chk("write_en", 32'(write_en), 32'(wf));
        if (rf) begin
            chk("win0", 32'(mem[read_addr]), 32'(sb[0]));
            chk("win1", 32'(mem[3'(int'(read_addr) + 1)]), 32'(sb[1]));
        end
        @(posedge clk);
        #1;
        if (fl) begin
            m_cnt = 0; m_wp = 0; m_rp = 0;
            sb.delete();
        end else begin
            if (rf) begin
                for (int i = 0; i < ST; i++) void'(sb.pop_front());
                m_rp = (m_rp + ST) % SIZE;
                m_cnt -= ST;
            end
            if (wf) begin
                sb.push_back(wdata0);
                sb.push_back(wdata1);
                m_wp = (m_wp + WS) % SIZE;
                m_cnt += WS;
            end
        end
        if (wf) next_word = next_word + 8'd2;
        wr_valid = 0;
        rd_ready = 0;
        flush    = 0;
    endtask

    initial begin
        for (int i = 0; i < SIZE; i++) mem[i] = 8'hxx;
        #2;
        chk_state();
        chk("write_en_rst", 32'(write_en), 32'(0));
        @(posedge clk);
        #1;
        rst = 1;

        // Fill to full, then a refused burst.
        repeat (4) step(1, 0, 0);
        step(1, 0, 0);
        step(1, 1, 0);
        repeat (2) step(0, 1, 0);

        // Asynchronous reset in the middle of a cycle with count=5.
        #2;
        rst = 0;
        #1;
        m_cnt = 0; m_wp = 0; m_rp = 0;
        sb.delete();
        chk_state();
        @(posedge clk);
        #1;
        chk_state();
        rst = 1;

        // Window: single burst, then read retires one word.
        step(1, 0, 0);
        step(0, 1, 0);
        step(0, 1, 0);

        // Reset and build count=6, wptr=6, rptr=0; then write+read together.
        rst = 0;
        #1;
        m_cnt = 0; m_wp = 0; m_rp = 0;
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1;
        repeat (3) step(1, 0, 0);
        step(1, 1, 0);
        chk_state();

        // Drain to rptr=7, count=1; refill to 3, then read across the wrap.
        repeat (6) step(0, 1, 0);
        step(1, 0, 0);
        step(0, 1, 0);
        chk("rd_wrap_addr", 32'(read_addr), 32'(0));

        // Flush with a concurrent burst.
        step(1, 0, 0);
        step(1, 0, 1);
        chk_state();

        // Recover after flush.
        step(1, 0, 0);
        step(1, 1, 0);
        step(0, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
